mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory between the fetch stage (read-only) and the memory stage (load/store).

---
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 tb/tb_mem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data ports with timeout and starvation guard
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_wstrb,
    output logic        dm_ready,
    output logic [31:0] dm_rdata,
    output logic        dm_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [SW-1:0] S_MAX  = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] streak;
    logic [TW-1:0] timer;
    logic          grant_dm, grant_if, busy, expire, done;

    // Arbitration, timeout detection and next-state selection
    always_comb begin
        grant_dm  = state == IDLE && dm_req && !(if_req && streak == S_MAX);
        grant_if  = state == IDLE && if_req && !grant_dm;
        busy      = state == BUSY_IF || state == BUSY_DM;
        expire    = TIMEOUT_CYCLES != 0 && busy && !mem_ready && timer == T_LAST;
        done      = busy && (mem_ready || expire);
        state_nxt = state == IDLE ? (grant_dm ? BUSY_DM : grant_if ? BUSY_IF : IDLE) :
                    state == RESP ? IDLE :
                    done          ? RESP : state;
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Memory-side request, requester responses, wait timer and fetch starvation streak
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if_ready  <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            dm_ready  <= 1'b0;
            dm_rdata  <= '0;
            dm_err    <= 1'b0;
            timer     <= '0;
            streak    <= '0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            timer    <= (busy && !done) ? timer + 1'b1 : '0;
            if (grant_dm || grant_if) begin
                mem_req   <= 1'b1;
                mem_we    <= grant_dm && dm_we;
                mem_addr  <= grant_dm ? dm_addr : if_addr;
                mem_wdata <= grant_dm ? dm_wdata : '0;
                mem_wstrb <= (grant_dm && dm_we) ? dm_wstrb : 4'b0000;
                if_err    <= 1'b0;
                dm_err    <= 1'b0;
                streak    <= (grant_dm && if_req) ? (streak == S_MAX ? streak : streak + 1'b1) : '0;
            end
            if (done) begin
                mem_req <= 1'b0;
                if (state == BUSY_IF) begin
                    if_ready <= 1'b1;
                    if_err   <= expire;
                    if_rdata <= expire ? '0 : mem_rdata;
                end else begin
                    dm_ready <= 1'b1;
                    dm_err   <= expire;
                    if (expire || !mem_we) dm_rdata <= expire ? '0 : mem_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
    localparam int TO = 8;
    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_req, dm_req, dm_we, mem_ready;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [3:0]  dm_wstrb;
    logic        if_ready, if_err, dm_ready, dm_err, mem_req, mem_we;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    mem_port_arbiter #(.TIMEOUT_CYCLES(TO), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 = waiting for a grant, 1 = access outstanding, 2 = reporting completion
    int          ph, owner_dm, waited, streak, dly;
    logic        e_mem_req, e_we, e_if_ready, e_if_err, e_dm_ready, e_dm_err;
    logic [31:0] e_addr, e_wdata, e_if_rdata, e_dm_rdata;
    logic [3:0]  e_wstrb;
    int          glog[$];

    int          fixed_dly = 0;
    bit          fix_rd = 1'b1;
    bit          noise = 1'b0;
    logic [31:0] rd_fix = '0;

    int          req_cycles;
    bit          got;
    logic [31:0] seen_addr, seen_wdata;
    logic        seen_we;
    logic [3:0]  seen_wstrb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = 0; owner_dm = 0; waited = 0; streak = 0; dly = 0;
        e_mem_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
        e_if_ready = 0; e_if_err = 0; e_if_rdata = '0;
        e_dm_ready = 0; e_dm_err = 0; e_dm_rdata = '0;
    endtask

    task automatic finish_access(input bit timed_out);
        e_mem_req = 0;
        ph = 2;
        if (owner_dm == 0) begin
            e_if_ready = 1; e_if_err = timed_out; e_if_rdata = timed_out ? 32'h0 : mem_rdata;
        end else begin
            e_dm_ready = 1; e_dm_err = timed_out;
            if (timed_out) e_dm_rdata = 32'h0;
            else if (!e_we) e_dm_rdata = mem_rdata;
        end
    endtask

    // Advance the model by one clock using the inputs the DUT will sample at the coming edge
    task automatic step_model();
        e_if_ready = 0;
        e_dm_ready = 0;
        if (ph == 0) begin
            if (dm_req && !(if_req && streak >= SL)) begin
                owner_dm = 1;
                e_we = dm_we; e_addr = dm_addr; e_wdata = dm_wdata; e_wstrb = dm_we ? dm_wstrb : 4'h0;
                streak = if_req ? (streak < SL ? streak + 1 : SL) : 0;
                glog.push_back(1);
            end else if (if_req) begin
                owner_dm = 0;
                e_we = 0; e_addr = if_addr; e_wstrb = 4'h0;
                streak = 0;
                glog.push_back(0);
            end
            if (dm_req || if_req) begin
                ph = 1; waited = 0; e_mem_req = 1; e_if_err = 0; e_dm_err = 0;
                dly = fixed_dly >= 0 ? fixed_dly :
                      ($urandom_range(0, 7) == 0 ? 99 : int'($urandom_range(0, 3)));
            end
        end else if (ph == 1) begin
            if (mem_ready) finish_access(1'b0);
            else begin
                waited++;
                if (TO != 0 && waited == TO) finish_access(1'b1);
            end
        end else begin
            ph = 0;
        end
    endtask

    task automatic compare_all();
        check("mem_req", mem_req, e_mem_req);
        check("if_ready", if_ready, e_if_ready);
        check("dm_ready", dm_ready, e_dm_ready);
        check("if_err", if_err, e_if_err);
        check("dm_err", dm_err, e_dm_err);
        check("if_rdata", if_rdata, e_if_rdata);
        check("dm_rdata", dm_rdata, e_dm_rdata);
        if (e_mem_req) begin
            check("mem_we", mem_we, e_we);
            check("mem_addr", mem_addr, e_addr);
            check("mem_wstrb", mem_wstrb, e_wstrb);
            if (e_we) check("mem_wdata", mem_wdata, e_wdata);
        end
    endtask

    // Called at a falling edge: check, drive the memory response, advance the model, move to the next falling edge
    task automatic cycle();
        compare_all();
        mem_ready = (ph == 1) ? (waited == dly) : (noise && $urandom_range(0, 3) == 0);
        mem_rdata = fix_rd ? rd_fix : $urandom;
        if (resetn) step_model();
        else model_reset();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_until(input bit want_dm);
        req_cycles = 0;
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            cycle();
            if (mem_req) begin
                req_cycles++;
                seen_addr = mem_addr; seen_we = mem_we; seen_wdata = mem_wdata; seen_wstrb = mem_wstrb;
            end
            if (want_dm ? dm_ready : if_ready) got = 1;
        end
        check("ready_within_bound", 32'(got), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 0; if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0; mem_rdata = '0;
        model_reset();
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_if_ready", if_ready, 0);
        check("rst_dm_ready", dm_ready, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        cycle();
        cycle();
        resetn = 1;

        // Fetch alone
        fixed_dly = 1; rd_fix = 32'hDEADBEEF;
        if_req = 1; if_addr = 32'h100;
        run_until(1'b0);
        check("fetch_addr", seen_addr, 32'h100);
        check("fetch_we", 32'(seen_we), 0);
        check("fetch_req_cycles", req_cycles, 2);
        check("fetch_rdata", if_rdata, 32'hDEADBEEF);
        check("fetch_err", if_err, 0);
        if_req = 0;
        cycle();
        check("fetch_single_pulse", if_ready, 0);

        // Store
        fixed_dly = 2; rd_fix = 32'h0BADF00D;
        dm_req = 1; dm_we = 1; dm_addr = 32'h2004; dm_wdata = 32'h55AA; dm_wstrb = 4'b0011;
        run_until(1'b1);
        check("store_addr", seen_addr, 32'h2004);
        check("store_we", 32'(seen_we), 1);
        check("store_wdata", seen_wdata, 32'h55AA);
        check("store_wstrb", seen_wstrb, 4'b0011);
        check("store_req_cycles", req_cycles, 3);
        check("store_rdata_kept", dm_rdata, 0);
        dm_req = 0; dm_we = 0;
        cycle();

        // Contention
        fixed_dly = 0; fix_rd = 0;
        glog.delete();
        if_req = 1; if_addr = 32'h400; dm_req = 1; dm_addr = 32'h3000;
        for (int k = 0; k < 100 && glog.size() < 10; k++) cycle();
        if_req = 0; dm_req = 0;
        for (int k = 0; k < 3; k++) cycle();
        begin
            int pat[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
            check("grant_count", 32'(glog.size() >= 10), 1);
            for (int k = 0; k < 10 && k < glog.size(); k++) check("grant_order", glog[k], pat[k]);
        end

        // Timeout
        fixed_dly = 99;
        dm_req = 1; dm_we = 0; dm_addr = 32'h40;
        run_until(1'b1);
        check("timeout_req_cycles", req_cycles, TO);
        check("timeout_err", dm_err, 1);
        check("timeout_rdata", dm_rdata, 0);
        dm_req = 0;
        cycle();
        fixed_dly = 0; fix_rd = 1; rd_fix = 32'h12345678;
        dm_req = 1;
        run_until(1'b1);
        check("after_timeout_err", dm_err, 0);
        check("after_timeout_rdata", dm_rdata, 32'h12345678);
        dm_req = 0;
        cycle();

        // Reset mid-access
        fixed_dly = 99;
        dm_req = 1; dm_we = 1; dm_addr = 32'h80; dm_wdata = 32'h1; dm_wstrb = 4'hF;
        cycle();
        cycle();
        check("pre_reset_mem_req", mem_req, 1);
        #2 resetn = 0;
        #1;
        check("async_rst_mem_req", mem_req, 0);
        check("async_rst_dm_ready", dm_ready, 0);
        check("async_rst_dm_err", dm_err, 0);
        dm_req = 0; dm_we = 0;
        model_reset();
        @(negedge clk);
        cycle();
        resetn = 1;
        fixed_dly = 0; rd_fix = 32'hCAFEF00D;
        if_req = 1; if_addr = 32'h300;
        run_until(1'b0);
        check("post_reset_fetch_addr", seen_addr, 32'h300);
        check("post_reset_fetch_rdata", if_rdata, 32'hCAFEF00D);
        check("post_reset_fetch_err", if_err, 0);
        if_req = 0;
        cycle();

        // Randomized traffic with stray mem_ready outside accesses
        fixed_dly = -1; fix_rd = 0; noise = 1;
        for (int n = 0; n < 3000; n++) begin
            if (e_if_ready) if_req = 0;
            else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (e_dm_ready) dm_req = 0;
            else if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1; dm_we = 1'($urandom); dm_addr = $urandom;
                dm_wdata = $urandom; dm_wstrb = 4'($urandom);
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
